// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush scheduler.
// The stages own the requests (master); the scheduler owns stall/flush/status (slave).
interface pipeline_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  stall_req_id;
    logic                  stall_req_ex;
    logic                  stall_req_mem;
    logic                  exc_req;
    logic [ADDR_WIDTH-1:0] exc_pc;
    logic                  eret_req;
    logic [ADDR_WIDTH-1:0] epc;

    logic [4:0]            stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic                  mem_timeout;
    logic [CNT_WIDTH-1:0]  stall_count;

    modport master (
        output stall_req_id, stall_req_ex, stall_req_mem,
        output exc_req, exc_pc, eret_req, epc,
        input  stall, flush, flush_pc, mem_timeout, stall_count
    );

    modport slave (
        input  stall_req_id, stall_req_ex, stall_req_mem,
        input  exc_req, exc_pc, eret_req, epc,
        output stall, flush, flush_pc, mem_timeout, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for a 5-stage MIPS pipeline: per-stage hold vector,
// one-cycle redirect flush, MEM-stall watchdog and stall-cycle counter.
module pipeline_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] flush_pc_q, flush_pc_d;
    logic                  mem_timeout_q, mem_timeout_d;
    logic [CNT_WIDTH-1:0]  stall_count_q, stall_count_d;

    logic [2:0]            hold_depth;
    logic [4:0]            stall_comb;
    logic                  mem_wait;
    logic                  wd_fire;

    // hold_depth = number of stages frozen from IF upward; the next stage bubbles.
    always_comb begin
        state_d    = state_q;
        flush_d    = 1'b0;
        flush_pc_d = flush_pc_q;
        hold_depth = 3'd0;
        mem_wait   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.exc_req || bus.eret_req) begin
                    state_d    = ST_FLUSH;
                    flush_d    = 1'b1;
                    flush_pc_d = bus.exc_req ? bus.exc_pc : bus.epc;
                end else if (bus.stall_req_mem) begin
                    hold_depth = 3'd4;
                    mem_wait   = 1'b1;
                end else if (bus.stall_req_ex) begin
                    hold_depth = 3'd3;
                end else if (bus.stall_req_id) begin
                    hold_depth = 3'd2;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst) begin
            hold_depth = 3'd0;
            mem_wait   = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : gen_stall_bit
            assign stall_comb[gi] = (hold_depth > 3'(gi));
        end
    endgenerate

    always_comb begin
        mem_timeout_d = wd_fire;
        stall_count_d = stall_count_q;
        if (|stall_comb) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT > 0) begin : gen_wd
            localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
            logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
            logic [WD_W-1:0] wd_inc;

            // Counter restarts at 0 after firing so a sustained stall re-fires periodically.
            always_comb begin
                wd_inc   = wd_cnt_q + 1'b1;
                wd_cnt_d = '0;
                wd_fire  = 1'b0;
                if (mem_wait) begin
                    if (wd_inc == WD_W'(MEM_TIMEOUT)) begin
                        wd_fire = 1'b1;
                    end else begin
                        wd_cnt_d = wd_inc;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_cnt_q <= '0;
                end else begin
                    wd_cnt_q <= wd_cnt_d;
                end
            end
        end else begin : gen_no_wd
            assign wd_fire = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            flush_q       <= 1'b0;
            flush_pc_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_q       <= flush_d;
            flush_pc_q    <= flush_pc_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall_comb;
    assign bus.flush       = flush_q;
    assign bus.flush_pc    = flush_pc_q;
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized traffic
// against a cycle-level behavioural model; a second instance has the watchdog off and a 4-bit counter.
module tb_pipeline_ctrl;
    localparam int AW  = 32;
    localparam int TMO = 16;
    localparam int CW  = 32;
    localparam int CW2 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          id_r, ex_r, mem_r, exc_r, eret_r;
    logic [AW-1:0] exc_pc_r, epc_r;

    pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW))  u_if ();
    pipeline_ctrl_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW2)) u_if0 ();

    assign u_if.stall_req_id   = id_r;
    assign u_if.stall_req_ex   = ex_r;
    assign u_if.stall_req_mem  = mem_r;
    assign u_if.exc_req        = exc_r;
    assign u_if.exc_pc         = exc_pc_r;
    assign u_if.eret_req       = eret_r;
    assign u_if.epc            = epc_r;
    assign u_if0.stall_req_id  = id_r;
    assign u_if0.stall_req_ex  = ex_r;
    assign u_if0.stall_req_mem = mem_r;
    assign u_if0.exc_req       = exc_r;
    assign u_if0.exc_pc        = exc_pc_r;
    assign u_if0.eret_req      = eret_r;
    assign u_if0.epc           = epc_r;

    pipeline_ctrl #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    pipeline_ctrl #(.ADDR_WIDTH(AW), .MEM_TIMEOUT(0), .CNT_WIDTH(CW2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (u_if0.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit            m_in_flush;
    logic          m_flush, m_timeout;
    logic [AW-1:0] m_flush_pc;
    logic [CW-1:0] m_count;
    int            m_run;

    // Observations
    logic [4:0]     exp_stall, obs_stall, obs_stall0;
    logic           obs_flush, obs_timeout, obs_flush0, obs_timeout0;
    logic [AW-1:0]  obs_pc, obs_pc0;
    logic [CW-1:0]  obs_count;
    logic [CW2-1:0] obs_count0;

    function automatic logic [4:0] model_stall();
        int depth;
        if (rst || m_in_flush || exc_r || eret_r) return 5'd0;
        depth = mem_r ? 4 : ex_r ? 3 : id_r ? 2 : 0;
        return 5'((1 << depth) - 1);
    endfunction

    // Applies the currently driven inputs for one cycle and advances the model.
    task automatic tick();
        #1;
        exp_stall  = model_stall();
        obs_stall  = u_if.stall;
        obs_stall0 = u_if0.stall;
        if (rst) begin
            m_in_flush = 0; m_flush = 0; m_timeout = 0;
            m_flush_pc = '0; m_count = '0; m_run = 0;
        end else begin
            if (exp_stall != 5'd0) m_count++;
            m_timeout = 1'b0;
            if (m_in_flush) begin
                m_in_flush = 0; m_flush = 0; m_run = 0;
            end else if (exc_r || eret_r) begin
                m_in_flush = 1; m_flush = 1; m_run = 0;
                m_flush_pc = exc_r ? exc_pc_r : epc_r;
            end else if (mem_r) begin
                m_run++;
                m_timeout = (m_run % TMO == 0);
            end else begin
                m_run = 0;
            end
        end
        @(posedge clk);
        #1;
        obs_flush    = u_if.flush;
        obs_pc       = u_if.flush_pc;
        obs_timeout  = u_if.mem_timeout;
        obs_count    = u_if.stall_count;
        obs_flush0   = u_if0.flush;
        obs_pc0      = u_if0.flush_pc;
        obs_timeout0 = u_if0.mem_timeout;
        obs_count0   = u_if0.stall_count;
    endtask

    task automatic set_idle();
        id_r = 0; ex_r = 0; mem_r = 0; exc_r = 0; eret_r = 0;
    endtask

    task automatic set_rand(input int mem_pct, input int redir_pct);
        id_r     = ($urandom_range(99) < 50);
        ex_r     = ($urandom_range(99) < 40);
        mem_r    = ($urandom_range(99) < mem_pct);
        exc_r    = ($urandom_range(99) < redir_pct);
        eret_r   = ($urandom_range(99) < redir_pct);
        exc_pc_r = $urandom;
        epc_r    = $urandom;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            set_rand(50, 50);
            tick();
            n_tests++;
            if (obs_stall !== 5'd0) begin
                n_fail++; $display("FAIL reset_stall cyc%0d: got %b want 00000", i, obs_stall);
            end
            n_tests++;
            if ({obs_flush, obs_timeout, obs_pc, obs_count} !== '0) begin
                n_fail++;
                $display("FAIL reset_regs cyc%0d: got flush=%b tmo=%b pc=%h cnt=%0d want all 0",
                         i, obs_flush, obs_timeout, obs_pc, obs_count);
            end
        end
        rst = 0;
        set_idle();
        tick();
        n_tests++;
        if (obs_stall !== 5'd0 || obs_flush !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got stall=%b flush=%b want 0/0", obs_stall, obs_flush);
        end
    endtask

    task automatic test_id_stall();
        set_idle();
        id_r = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (obs_stall !== 5'b00011) begin
                n_fail++; $display("FAIL id_stall cyc%0d: got %b want 00011", i, obs_stall);
            end
        end
        n_tests++;
        if (obs_count !== 32'd3) begin
            n_fail++; $display("FAIL id_count: got %0d want 3", obs_count);
        end
        set_idle();
        tick();
    endtask

    task automatic test_priority();
        set_idle();
        id_r = 1; ex_r = 1; mem_r = 1;
        tick();
        n_tests++;
        if (obs_stall !== 5'b01111) begin
            n_fail++; $display("FAIL prio_mem: got %b want 01111", obs_stall);
        end
        mem_r = 0;
        tick();
        n_tests++;
        if (obs_stall !== 5'b00111) begin
            n_fail++; $display("FAIL prio_ex: got %b want 00111", obs_stall);
        end
        ex_r = 0;
        tick();
        n_tests++;
        if (obs_stall !== 5'b00011) begin
            n_fail++; $display("FAIL prio_id: got %b want 00011", obs_stall);
        end
        set_idle();
        tick();
    endtask

    task automatic test_exception();
        set_idle();
        exc_r = 1; exc_pc_r = 32'hBFC00380; ex_r = 1;
        tick();
        n_tests++;
        if (obs_stall !== 5'd0) begin
            n_fail++; $display("FAIL exc_stall: got %b want 00000", obs_stall);
        end
        n_tests++;
        if (obs_flush !== 1'b1 || obs_pc !== 32'hBFC00380) begin
            n_fail++; $display("FAIL exc_flush: got flush=%b pc=%h want 1/bfc00380", obs_flush, obs_pc);
        end
        exc_r = 0;
        tick();
        n_tests++;
        if (obs_stall !== 5'd0) begin
            n_fail++; $display("FAIL flush_ignores_ex: got %b want 00000", obs_stall);
        end
        n_tests++;
        if (obs_flush !== 1'b0) begin
            n_fail++; $display("FAIL flush_one_cycle: got %b want 0", obs_flush);
        end
        tick();
        n_tests++;
        if (obs_stall !== 5'b00111) begin
            n_fail++; $display("FAIL after_flush_ex: got %b want 00111", obs_stall);
        end
        set_idle();
        tick();
    endtask

    task automatic test_exc_eret();
        set_idle();
        exc_r = 1; eret_r = 1; exc_pc_r = 32'h80000180; epc_r = 32'h00400010;
        tick();
        n_tests++;
        if (obs_pc !== 32'h80000180) begin
            n_fail++; $display("FAIL exc_over_eret: got %h want 80000180", obs_pc);
        end
        set_idle();
        tick();
        eret_r = 1;
        tick();
        n_tests++;
        if (obs_flush !== 1'b1 || obs_pc !== 32'h00400010) begin
            n_fail++; $display("FAIL eret_pc: got flush=%b pc=%h want 1/00400010", obs_flush, obs_pc);
        end
        set_idle();
        tick();
        tick();
        n_tests++;
        if (obs_flush !== 1'b0 || obs_pc !== 32'h00400010) begin
            n_fail++; $display("FAIL pc_hold: got flush=%b pc=%h want 0/00400010", obs_flush, obs_pc);
        end
    endtask

    task automatic test_watchdog();
        int pulses;
        int pulses0;
        pulses  = 0;
        pulses0 = 0;
        set_idle();
        tick();
        mem_r = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            n_tests++;
            if (obs_stall !== 5'b01111) begin
                n_fail++; $display("FAIL wd_stall k=%0d: got %b want 01111", k, obs_stall);
            end
            n_tests++;
            if (obs_timeout !== ((k == 16) || (k == 32))) begin
                n_fail++; $display("FAIL wd_pulse k=%0d: got %b want %b", k, obs_timeout, (k == 16) || (k == 32));
            end
            if (obs_timeout === 1'b1) pulses++;
            if (obs_timeout0 !== 1'b0) pulses0++;
        end
        n_tests++;
        if (pulses !== 2) begin
            n_fail++; $display("FAIL wd_pulse_count: got %0d want 2", pulses);
        end
        n_tests++;
        if (pulses0 !== 0) begin
            n_fail++; $display("FAIL wd_off: got %0d pulses want 0", pulses0);
        end
        set_idle();
        tick();
    endtask

    task automatic test_random(input int cycles, input int mem_pct, input int redir_pct);
        for (int i = 0; i < cycles; i++) begin
            set_rand(mem_pct, redir_pct);
            rst = ($urandom_range(199) == 0);
            tick();
            n_tests++;
            if (obs_stall !== exp_stall || obs_stall0 !== exp_stall) begin
                n_fail++; $display("FAIL rnd_stall cyc%0d: got %b/%b want %b", i, obs_stall, obs_stall0, exp_stall);
            end
            n_tests++;
            if (obs_flush !== m_flush || obs_pc !== m_flush_pc || obs_flush0 !== m_flush || obs_pc0 !== m_flush_pc) begin
                n_fail++;
                $display("FAIL rnd_flush cyc%0d: got %b/%h (%b/%h) want %b/%h",
                         i, obs_flush, obs_pc, obs_flush0, obs_pc0, m_flush, m_flush_pc);
            end
            n_tests++;
            if (obs_timeout !== m_timeout || obs_timeout0 !== 1'b0) begin
                n_fail++; $display("FAIL rnd_timeout cyc%0d: got %b/%b want %b/0", i, obs_timeout, obs_timeout0, m_timeout);
            end
            n_tests++;
            if (obs_count !== m_count || obs_count0 !== m_count[CW2-1:0]) begin
                n_fail++;
                $display("FAIL rnd_count cyc%0d: got %0d/%0d want %0d/%0d",
                         i, obs_count, obs_count0, m_count, m_count[CW2-1:0]);
            end
        end
        rst = 0;
        set_idle();
        tick();
    endtask

    initial begin
        rst = 1;
        set_idle();
        exc_pc_r = '0;
        epc_r    = '0;
        m_in_flush = 0; m_flush = 0; m_timeout = 0;
        m_flush_pc = '0; m_count = '0; m_run = 0;
        test_reset();
        test_id_stall();
        test_priority();
        test_exception();
        test_exc_eret();
        test_watchdog();
        test_random(400, 50, 8);
        test_random(400, 92, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
